// File: rtl/ex_mem_slice.sv
// rtl/ex_mem_slice.sv - EX/MEM pipeline register with condition flags and hazard detect
module ex_mem_slice #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [2:0]    ex_M,
  input  logic [1:0]    ex_WB,
  input  logic [2:0]    ex_bcond,
  input  logic [RW-1:0] ex_dst,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_wdata,
  input  logic [DW-1:0] ex_pcbranch,
  input  logic [2:0]    ex_flags,
  input  logic [2:0]    ex_flag_we,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic [2:0]    M,
  output logic [1:0]    WB,
  output logic [2:0]    bcond,
  output logic [RW-1:0] dst,
  output logic [DW-1:0] ALU,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] PCbranch,
  output logic [2:0]    flags,
  output logic          valid,
  output logic          fwd_en,
  output logic          load_use
);

  always_ff @(posedge clk) begin
    if (rst) begin
      M        <= '0;
      WB       <= '0;
      bcond    <= '0;
      dst      <= '0;
      ALU      <= '0;
      wdata    <= '0;
      PCbranch <= '0;
      flags    <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      // Bubble only kills side effects; payload is left as-is.
      valid <= 1'b0;
      M     <= '0;
      WB    <= '0;
    end else if (!stall) begin
      valid    <= ex_valid;
      M        <= ex_valid ? ex_M  : 3'b000;
      WB       <= ex_valid ? ex_WB : 2'b00;
      bcond    <= ex_bcond;
      dst      <= ex_dst;
      ALU      <= ex_alu;
      wdata    <= ex_wdata;
      PCbranch <= ex_pcbranch;
      if (ex_valid) begin
        flags <= (flags & ~ex_flag_we) | (ex_flags & ex_flag_we);
      end
    end
  end

  assign fwd_en   = valid & WB[0] & ~M[0];
  assign load_use = valid & M[0] & WB[0] & ((dst == id_rs) | (dst == id_rt));

endmodule

// File: tb/tb_ex_mem_slice.sv
// tb/tb_ex_mem_slice.sv - scoreboard bench for ex_mem_slice with random and directed stimulus
module tb_ex_mem_slice;

  typedef struct {
    logic        rst, stall, flush, v;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [2:0]  bc;
    logic [3:0]  dst;
    logic [15:0] alu, wd, pcb;
    logic [2:0]  fl, we;
    logic [3:0]  rs, rt;
  } stim_t;

  typedef struct {
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [2:0]  bc;
    logic [3:0]  dst;
    logic [15:0] alu, wd, pcb;
    logic [2:0]  fl;
    logic        valid, fwd, lu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [2:0]  ex_M, ex_bcond, ex_flags, ex_flag_we;
  logic [1:0]  ex_WB;
  logic [3:0]  ex_dst, id_rs, id_rt;
  logic [15:0] ex_alu, ex_wdata, ex_pcbranch;
  logic [2:0]  M, bcond, flags;
  logic [1:0]  WB;
  logic [3:0]  dst;
  logic [15:0] ALU, wdata, PCbranch;
  logic        valid, fwd_en, load_use;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t st;

  always #5 clk = ~clk;

  ex_mem_slice #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_M(ex_M), .ex_WB(ex_WB), .ex_bcond(ex_bcond), .ex_dst(ex_dst),
    .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_pcbranch(ex_pcbranch),
    .ex_flags(ex_flags), .ex_flag_we(ex_flag_we), .id_rs(id_rs), .id_rt(id_rt),
    .M(M), .WB(WB), .bcond(bcond), .dst(dst), .ALU(ALU), .wdata(wdata),
    .PCbranch(PCbranch), .flags(flags), .valid(valid), .fwd_en(fwd_en),
    .load_use(load_use)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst:0, stall:0, flush:0, v:0, m:0, wb:0, bc:0, dst:0, alu:0, wd:0,
          pcb:0, fl:0, we:0, rs:0, rt:0};
    return s;
  endfunction

  // Architectural reference: the stage as a record updated by the ordered rules.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.v;
    ex_M = s.m; ex_WB = s.wb; ex_bcond = s.bc; ex_dst = s.dst;
    ex_alu = s.alu; ex_wdata = s.wd; ex_pcbranch = s.pcb;
    ex_flags = s.fl; ex_flag_we = s.we; id_rs = s.rs; id_rt = s.rt;
    if (s.rst) begin
      st = '{m:0, wb:0, bc:0, dst:0, alu:0, wd:0, pcb:0, fl:0, valid:0, fwd:0, lu:0};
    end else if (s.flush) begin
      st.valid = 0; st.m = 0; st.wb = 0;
    end else if (!s.stall) begin
      st.valid = s.v;
      st.m = s.v ? s.m : 3'b000;
      st.wb = s.v ? s.wb : 2'b00;
      st.bc = s.bc; st.dst = s.dst; st.alu = s.alu; st.wd = s.wd; st.pcb = s.pcb;
      if (s.v)
        for (int i = 0; i < 3; i++)
          if (s.we[i]) st.fl[i] = s.fl[i];
    end
    e = st;
    e.fwd = st.valid && st.wb[0] && !st.m[0];
    e.lu  = st.valid && st.m == 3'b001 || (st.valid && st.m[0]) ?
            (st.valid && st.m[0] && st.wb[0] && (st.dst == s.rs || st.dst == s.rt)) : 1'b0;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("M", 16'(M), 16'(e.m));
        chk("WB", 16'(WB), 16'(e.wb));
        chk("bcond", 16'(bcond), 16'(e.bc));
        chk("dst", 16'(dst), 16'(e.dst));
        chk("ALU", ALU, e.alu);
        chk("wdata", wdata, e.wd);
        chk("PCbranch", PCbranch, e.pcb);
        chk("flags", 16'(flags), 16'(e.fl));
        chk("valid", 16'(valid), 16'(e.valid));
        chk("fwd_en", 16'(fwd_en), 16'(e.fwd));
        chk("load_use", 16'(load_use), 16'(e.lu));
      end
    end
  end

  initial begin : driver
    stim_t s;
    st = '{m:0, wb:0, bc:0, dst:0, alu:0, wd:0, pcb:0, fl:0, valid:0, fwd:0, lu:0};
    // Reset beats stall, flush and a valid input.
    s = idle(); s.rst = 1; s.stall = 1; s.flush = 1; s.v = 1; s.m = 3'b111; s.wb = 2'b11;
    s.alu = 16'hAAAA; s.fl = 3'b111; s.we = 3'b111; s.dst = 4'd9;
    step(s);
    s = idle(); s.v = 1; s.fl = 3'b111; s.we = 3'b100; s.alu = 16'h1234; step(s);
    s = idle(); s.v = 1; s.fl = 3'b011; s.we = 3'b011; s.alu = 16'h1234; step(s);
    s = idle(); s.stall = 1; s.v = 1; s.alu = 16'hBEEF; s.we = 3'b111; s.fl = 3'b000;
    s.m = 3'b010; s.wb = 2'b10;
    repeat (3) step(s);
    s.stall = 0; step(s);
    s = idle(); s.v = 1; s.m = 3'b100; s.wb = 2'b01; s.alu = 16'h5555; s.pcb = 16'h0040; step(s);
    s = idle(); s.flush = 1; s.v = 1; s.m = 3'b010; s.alu = 16'h7777; s.we = 3'b111; s.fl = 3'b111;
    step(s);
    s = idle(); s.v = 0; s.m = 3'b011; s.wb = 2'b11; s.we = 3'b111; s.fl = 3'b101; step(s);
    s = idle(); s.v = 1; s.m = 3'b001; s.wb = 2'b11; s.dst = 4'd5; s.rs = 4'd5; s.rt = 4'd1;
    step(s);
    s.stall = 1; s.rs = 4'd2; s.rt = 4'd7; step(s);
    s.rt = 4'd5; step(s);
    s = idle(); s.v = 1; s.m = 3'b000; s.wb = 2'b01; s.dst = 4'd3; s.rs = 4'd3; step(s);
    s = idle(); s.rst = 1; s.stall = 1; s.v = 1; s.alu = 16'h9999; step(s);
    for (int n = 0; n < 500; n++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.v     = ($urandom_range(0, 3) != 0);
      s.m     = 3'($urandom);
      s.wb    = 2'($urandom);
      s.bc    = 3'($urandom);
      s.dst   = 4'($urandom_range(0, 7));
      s.alu   = 16'($urandom);
      s.wd    = 16'($urandom);
      s.pcb   = 16'($urandom);
      s.fl    = 3'($urandom);
      s.we    = 3'($urandom);
      s.rs    = 4'($urandom_range(0, 7));
      s.rt    = 4'($urandom_range(0, 7));
      step(s);
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
